// File: rtl/ioports_pkg.sv
// Shared definitions for the host byte-protocol responder: command nibbles,
// well-known port numbers and the state encodings of both FSMs.
package ioports_pkg;

    localparam logic [3:0] CMD_WRITE = 4'b0010;
    localparam logic [3:0] CMD_READ  = 4'b0011;

    localparam logic [3:0] PORT_STATUS      = 4'd1;
    localparam logic [3:0] PORT_CODEC_DATA  = 4'd2;
    localparam logic [3:0] PORT_CODEC_REGID = 4'd3;
    localparam logic [3:0] PORT_CODEC_CMD   = 4'd15;

    // state          | meaning
    // ST_IDLE        | waiting for a command byte
    // ST_WR_COLLECT  | gathering the 4 data bytes of a WRITE
    // ST_WR_COMMIT   | wr_en pulse with the assembled word
    // ST_RD_REQ      | rd_en pulse to the register bank
    // ST_RD_LATCH    | rd_data valid; hand it to the serializer
    // ST_TX          | serializer sending the 4 reply bytes
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_COLLECT,
        ST_WR_COMMIT,
        ST_RD_REQ,
        ST_RD_LATCH,
        ST_TX
    } state_t;

    // state          | meaning
    // TX_IDLE        | nothing to send
    // TX_LOAD        | waiting for tx_ready, then strobe tx_en
    // TX_WAIT_BUSY   | waiting for the transmitter to drop tx_ready
    // TX_WAIT_DONE   | waiting for tx_ready to return, then next byte
    typedef enum logic [1:0] {
        TX_IDLE,
        TX_LOAD,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_t;

    function automatic logic is_known_cmd(input logic [3:0] nib);
        return (nib == CMD_WRITE) || (nib == CMD_READ);
    endfunction

endpackage

// File: rtl/ioports_cmd_slave_if.sv
// Bus bundle between the UART/register-bank side (master) and the
// command responder (slave).
interface ioports_cmd_slave_if;

    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_ready;
    logic        tx_en;
    logic [7:0]  tx_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        cmd_err;

    modport slave (
        input  rx_ready, rx_data, tx_ready, rd_data,
        output tx_en, tx_data, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy, cmd_err
    );

    modport master (
        output rx_ready, rx_data, tx_ready, rd_data,
        input  tx_en, tx_data, wr_en, wr_addr, wr_data, rd_en, rd_addr, busy, cmd_err
    );

endinterface

// File: rtl/ioports_tx_serializer.sv
// Sends a 32-bit word as 4 bytes, MSB first, pacing each byte on the
// transmitter's tx_ready fall/rise so no byte is loaded while one is in flight.
module ioports_tx_serializer
    import ioports_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data,
    input  logic        tx_ready,
    output logic        tx_en,
    output logic [7:0]  tx_data,
    output logic        done
);

    tx_state_t   state, state_nxt;
    logic [31:0] shift;
    logic [1:0]  idx;

    // State register plus word/index bookkeeping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= TX_IDLE;
            shift <= '0;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == TX_IDLE && start) begin
                shift <= data;
                idx   <= '0;
            end else if (state == TX_WAIT_DONE && tx_ready) begin
                shift <= {shift[23:0], 8'h00};
                idx   <= idx + 2'd1;
            end
        end
    end

    // Next state and handshake strobes.
    always_comb begin
        state_nxt = state;
        tx_en     = 1'b0;
        done      = 1'b0;
        case (state)
            TX_IDLE: begin
                if (start) state_nxt = TX_LOAD;
            end
            TX_LOAD: begin
                if (tx_ready) begin
                    tx_en     = 1'b1;
                    state_nxt = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (!tx_ready) state_nxt = TX_WAIT_DONE;
            end
            TX_WAIT_DONE: begin
                if (tx_ready) begin
                    if (idx == 2'd3) begin
                        done      = 1'b1;
                        state_nxt = TX_IDLE;
                    end else begin
                        state_nxt = TX_LOAD;
                    end
                end
            end
            default: state_nxt = TX_IDLE;
        endcase
    end

    // The shift register empties to zero after the last byte, so tx_data
    // idles at 0 without extra gating.
    assign tx_data = shift[31:24];

endmodule

// File: rtl/ioports_cmd_slave.sv
// Host byte-protocol responder: parses WRITE/READ command bytes from the
// UART receiver, drives the register-bank strobes and returns read words
// through the UART transmitter.
module ioports_cmd_slave
    import ioports_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10_000_000,
    parameter int TO_W           = 24
) (
    input  logic clock,
    input  logic reset,
    ioports_cmd_slave_if.slave bus
);

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

    state_t          state, state_nxt;
    logic [3:0]      wr_addr_q;
    logic [3:0]      rd_addr_q;
    logic [31:0]     wr_shift;
    logic [1:0]      byte_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            cmd_err_q;
    logic [3:0]      rx_nib;
    logic            tx_start;
    logic            tx_done;

    assign rx_nib   = bus.rx_data[7:4];
    assign tx_start = (state == ST_RD_LATCH);

    // State register, address/word capture and the cmd_err pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            wr_shift  <= '0;
            byte_cnt  <= '0;
            cmd_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cmd_err_q <= (state == ST_IDLE) && bus.rx_ready && !is_known_cmd(rx_nib);
            if (state == ST_IDLE && bus.rx_ready && rx_nib == CMD_WRITE) begin
                wr_addr_q <= bus.rx_data[3:0];
                byte_cnt  <= '0;
            end
            if (state == ST_IDLE && bus.rx_ready && rx_nib == CMD_READ) begin
                rd_addr_q <= bus.rx_data[3:0];
            end
            if (state == ST_WR_COLLECT && bus.rx_ready) begin
                wr_shift <= {wr_shift[23:0], bus.rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end
        end
    end

    // Inter-byte timeout: restarts on each data byte, saturates at the
    // limit, and sits at zero outside WR_COLLECT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (state != ST_WR_COLLECT || bus.rx_ready) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_LIMIT) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Command sequencing; bytes arriving outside IDLE/WR_COLLECT are ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.rx_ready) begin
                    if (rx_nib == CMD_WRITE)     state_nxt = ST_WR_COLLECT;
                    else if (rx_nib == CMD_READ) state_nxt = ST_RD_REQ;
                end
            end
            ST_WR_COLLECT: begin
                if (bus.rx_ready) begin
                    if (byte_cnt == 2'd3) state_nxt = ST_WR_COMMIT;
                end else if (to_cnt == TO_LIMIT) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_WR_COMMIT: state_nxt = ST_IDLE;
            ST_RD_REQ:    state_nxt = ST_RD_LATCH;
            ST_RD_LATCH:  state_nxt = ST_TX;
            ST_TX: begin
                if (tx_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    ioports_tx_serializer u_tx (
        .clock    (clock),
        .reset    (reset),
        .start    (tx_start),
        .data     (bus.rd_data),
        .tx_ready (bus.tx_ready),
        .tx_en    (bus.tx_en),
        .tx_data  (bus.tx_data),
        .done     (tx_done)
    );

    assign bus.wr_en   = (state == ST_WR_COMMIT);
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_shift;
    assign bus.rd_en   = (state == ST_RD_REQ);
    assign bus.rd_addr = rd_addr_q;
    assign bus.busy    = (state != ST_IDLE);
    assign bus.cmd_err = cmd_err_q;

endmodule

// File: tb/tb_ioports_cmd_slave.sv
// Scoreboard bench for ioports_cmd_slave: stimulus pushes expected strobes
// into queues, a negedge monitor pops and compares as the DUT emits them.
module tb_ioports_cmd_slave;
    import ioports_pkg::*;

    localparam int TO = 1000;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ioports_cmd_slave_if bus ();

    ioports_cmd_slave #(.TIMEOUT_CYCLES(TO), .TO_W(24)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    int last_rx    = 0;
    int tx_count   = 0;
    int exp_err    = 0;
    logic busy_chk = 1'b0;
    logic tx_fell  = 1'b0;
    logic tx_armed = 1'b1;
    logic [31:0] rd_value = '0;

    wr_t        exp_wr[$];
    logic [3:0] exp_rd[$];
    logic [7:0] exp_tx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Register bank: read word is valid the cycle after rd_en, zero otherwise.
    always @(posedge clock) bus.rd_data <= bus.rd_en ? rd_value : 32'h0;

    // UART transmitter: drops tx_ready for a few cycles after each load.
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(negedge clock);
            if (bus.tx_en && !reset) begin
                @(posedge clock);
                #1 bus.tx_ready = 1'b0;
                repeat (6) @(posedge clock);
                #1 bus.tx_ready = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (bus.rx_ready) last_rx = cyc;
                if (busy_chk) begin
                    check("busy_after_wr", 32'(bus.busy), 0);
                    busy_chk = 1'b0;
                end
                if (!bus.tx_ready) tx_fell = 1'b1;
                if (bus.tx_ready && tx_fell) tx_armed = 1'b1;
                if (bus.wr_en) begin
                    wr_t e;
                    check("wr_rd_exclusive", 32'(bus.rd_en), 0);
                    if (exp_wr.size() == 0) begin
                        check("unexpected_wr_en", 1, 0);
                    end else begin
                        e = exp_wr.pop_front();
                        check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                        check("wr_data", bus.wr_data, e.data);
                        check("wr_latency", cyc, last_rx + 1);
                        busy_chk = 1'b1;
                    end
                end
                if (bus.rd_en) begin
                    if (exp_rd.size() == 0) check("unexpected_rd_en", 1, 0);
                    else check("rd_addr", 32'(bus.rd_addr), 32'(exp_rd.pop_front()));
                end
                if (bus.tx_en) begin
                    check("tx_en_while_ready", 32'(bus.tx_ready), 1);
                    check("tx_handshake", 32'(tx_armed), 1);
                    tx_armed = 1'b0;
                    tx_fell  = 1'b0;
                    if (exp_tx.size() == 0) check("unexpected_tx_en", 1, 0);
                    else check("tx_data", 32'(bus.tx_data), 32'(exp_tx.pop_front()));
                    tx_count++;
                end
                if (bus.cmd_err) begin
                    check("cmd_err_expected", 32'(exp_err > 0), 1);
                    if (exp_err > 0) exp_err--;
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock);
        #1 bus.rx_ready = 1'b1;
        bus.rx_data = b;
        @(posedge clock);
        #1 bus.rx_ready = 1'b0;
        bus.rx_data = 8'h00;
    endtask

    task automatic send_write(input logic [3:0] port, input logic [31:0] word);
        send_byte({CMD_WRITE, port});
        for (int i = 3; i >= 0; i--) send_byte(word[i*8 +: 8]);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        @(negedge clock);
        while (bus.busy && n < budget) begin
            @(negedge clock);
            n++;
        end
        check(name, 32'(bus.busy), 0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_strobes"}, 32'({bus.wr_en, bus.rd_en, bus.tx_en, bus.busy, bus.cmd_err}), 0);
        check({name, "_wr_data"}, bus.wr_data, 0);
        check({name, "_addr_txd"}, 32'({bus.wr_addr, bus.rd_addr, bus.tx_data}), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (3) @(negedge clock);
        check_outputs_zero("reset_state");
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);

        // 1: WRITE to codec data port.
        exp_wr.push_back('{addr: PORT_CODEC_DATA, data: 32'h0000_0307});
        send_write(PORT_CODEC_DATA, 32'h0000_0307);
        wait_idle("t1_idle", 20);

        // 2: READ from status port, 4 reply bytes MSB first.
        rd_value = 32'hA5C3_1F02;
        exp_rd.push_back(PORT_STATUS);
        exp_tx.push_back(8'hA5); exp_tx.push_back(8'hC3);
        exp_tx.push_back(8'h1F); exp_tx.push_back(8'h02);
        tx_count = 0;
        send_byte({CMD_READ, PORT_STATUS});
        wait_idle("t2_idle", 300);
        check("t2_tx_count", tx_count, 4);

        // 3: unknown commands.
        exp_err += 2;
        send_byte(8'h45);
        send_byte(8'hFF);
        repeat (3) @(posedge clock);
        check("t3_err_drained", exp_err, 0);
        wait_idle("t3_idle", 1);

        // 4: partial WRITE times out, then a full WRITE to the command port.
        send_byte({CMD_WRITE, PORT_CODEC_CMD});
        send_byte(8'h12);
        repeat (TO + 10) @(posedge clock);
        wait_idle("t4_timeout_idle", 1);
        exp_wr.push_back('{addr: PORT_CODEC_CMD, data: 32'h0000_0001});
        send_write(PORT_CODEC_CMD, 32'h0000_0001);
        wait_idle("t4_idle", 20);

        // 5: byte injected mid-reply is ignored.
        rd_value = 32'h1234_5678;
        exp_rd.push_back(PORT_CODEC_REGID);
        exp_tx.push_back(8'h12); exp_tx.push_back(8'h34);
        exp_tx.push_back(8'h56); exp_tx.push_back(8'h78);
        tx_count = 0;
        send_byte({CMD_READ, PORT_CODEC_REGID});
        for (int i = 0; i < 200 && tx_count < 2; i++) @(negedge clock);
        check("t5_reached_2nd_byte", 32'(tx_count >= 2), 1);
        send_byte(8'h22);
        wait_idle("t5_idle", 300);
        check("t5_tx_count", tx_count, 4);

        // 6: reset in the middle of a WRITE, then a clean WRITE.
        send_byte(8'h25);
        send_byte(8'h11);
        send_byte(8'h22);
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        check_outputs_zero("t6_in_reset");
        @(posedge clock);
        #1 reset = 1'b0;
        exp_wr.push_back('{addr: PORT_CODEC_REGID, data: 32'hDEAD_BEEF});
        send_write(PORT_CODEC_REGID, 32'hDEAD_BEEF);
        wait_idle("t6_idle", 20);

        repeat (20) @(posedge clock);
        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        check("tx_queue_drained", exp_tx.size(), 0);
        check("err_drained", exp_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
